// File: rtl/mem_port_arbiter.sv
// Shares one single-port main memory between instruction fetch and the
// load/store data path. Conflicts are resolved round-robin, each access runs
// for WAIT_CYCLES memory cycles, and completion is signalled by a one-cycle
// ack with the read data already registered on the requesting side.
module mem_port_arbiter #(
  parameter int ADDR_BITS   = 64,
  parameter int DATA_BITS   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic [DATA_BITS-1:0] if_rdata,
  output logic                 if_ack,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [DATA_BITS-1:0] d_wdata,
  output logic [DATA_BITS-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 mem_en,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  // Access counter is 4 bits wide, enough for WAIT_CYCLES up to 15.
  localparam logic [3:0] COUNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]           state;
  logic [3:0]           count;
  logic                 last_grant;   // 1 = data side was granted last
  logic                 sel_data;     // side owning the current transaction
  logic                 wr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;

  logic                 grant_any;
  logic                 grant_data;

  // Round-robin choice: on conflict the side not served last wins.
  always_comb begin
    grant_any  = if_req | d_req;
    grant_data = 1'b0;
    if (if_req && d_req) begin
      grant_data = ~last_grant;
    end else if (d_req) begin
      grant_data = 1'b1;
    end
  end

  // Sequencer: latch the granted request, count out the access, then ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      last_grant <= 1'b1;
      sel_data   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state      <= S_ACCESS;
            count      <= COUNT_INIT;
            sel_data   <= grant_data;
            last_grant <= grant_data;
            // Fetches are always reads, whatever d_write says.
            wr_q       <= grant_data & d_write;
            addr_q     <= grant_data ? d_addr : if_addr;
            wdata_q    <= grant_data ? d_wdata : '0;
          end
        end
        S_ACCESS: begin
          if (count == 4'd0) begin
            state <= S_ACK;
            if (!wr_q) begin
              if (sel_data) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory-side and ack outputs decode from registered state only, so no
  // request input has a combinational path to the memory port.
  always_comb begin
    busy      = (state != S_IDLE);
    mem_en    = (state == S_ACCESS);
    mem_write = (state == S_ACCESS) && (count == 4'd0) && wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state == S_ACK) && !sel_data;
    d_ack     = (state == S_ACK) && sel_data;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-exact checks of fetch, store,
// arbitration, latched inputs, asynchronous reset and wait-count extremes.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clock;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, d_ack, mem_en, mem_write, busy;

  logic [DW-1:0] if_rdata_w1, d_rdata_w1, mem_wdata_w1;
  logic [AW-1:0] mem_addr_w1;
  logic          if_ack_w1, d_ack_w1, mem_en_w1, mem_write_w1, busy_w1;

  logic [DW-1:0] if_rdata_w15, d_rdata_w15, mem_wdata_w15;
  logic [AW-1:0] mem_addr_w15;
  logic          if_ack_w15, d_ack_w15, mem_en_w15, mem_write_w15, busy_w15;

  int total_cnt = 0;
  int pass_cnt  = 0;

  mem_port_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .WAIT_CYCLES(1)) dut_w1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w1), .if_ack(if_ack_w1),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_w1), .d_ack(d_ack_w1),
    .mem_en(mem_en_w1), .mem_write(mem_write_w1), .mem_addr(mem_addr_w1),
    .mem_wdata(mem_wdata_w1), .mem_rdata(mem_rdata), .busy(busy_w1)
  );

  mem_port_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .WAIT_CYCLES(15)) dut_w15 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w15), .if_ack(if_ack_w15),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_w15), .d_ack(d_ack_w15),
    .mem_en(mem_en_w15), .mem_write(mem_write_w15), .mem_addr(mem_addr_w15),
    .mem_wdata(mem_wdata_w15), .mem_rdata(mem_rdata), .busy(busy_w15)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; observe 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_write = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    reset_dut();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (mem_en !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL reset_mem_ctl got en=%0b wr=%0b want 0/0", mem_en, mem_write);
    else pass_cnt++;
    total_cnt++;
    if (if_ack !== 1'b0 || d_ack !== 1'b0)
      $display("FAIL reset_acks got if=%0b d=%0b want 0/0", if_ack, d_ack);
    else pass_cnt++;
    total_cnt++;
    if (if_rdata !== 64'd0 || d_rdata !== 64'd0 || mem_addr !== 64'd0)
      $display("FAIL reset_data got ir=%h dr=%h ma=%h want 0", if_rdata, d_rdata, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    bit saw_dack = 0;
    if_addr   = 64'h40;
    mem_rdata = 64'hF800_0000;
    d_write   = 1'b1;   // must be ignored for a fetch
    if_req    = 1'b1;
    tick();  // cycle 1
    saw_dack |= d_ack;
    total_cnt++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h40)
      $display("FAIL fetch_c1 got en=%0b addr=%h want 1/40", mem_en, mem_addr);
    else pass_cnt++;
    tick();  // cycle 2
    saw_dack |= d_ack;
    total_cnt++;
    if (mem_en !== 1'b1 || mem_write !== 1'b0)
      $display("FAIL fetch_c2 got en=%0b wr=%0b want 1/0", mem_en, mem_write);
    else pass_cnt++;
    total_cnt++;
    if (if_ack !== 1'b0) $display("FAIL fetch_early_ack got %0b want 0", if_ack); else pass_cnt++;
    tick();  // cycle 3
    saw_dack |= d_ack;
    total_cnt++;
    if (if_ack !== 1'b1 || mem_en !== 1'b0)
      $display("FAIL fetch_c3 got ack=%0b en=%0b want 1/0", if_ack, mem_en);
    else pass_cnt++;
    total_cnt++;
    if (if_rdata !== 64'hF800_0000)
      $display("FAIL fetch_rdata got %h want f8000000", if_rdata);
    else pass_cnt++;
    if_req  = 1'b0;
    d_write = 1'b0;
    tick();  // cycle 4
    saw_dack |= d_ack;
    total_cnt++;
    if (if_ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL fetch_c4 got ack=%0b busy=%0b want 0/0", if_ack, busy);
    else pass_cnt++;
    total_cnt++;
    if (saw_dack !== 1'b0) $display("FAIL fetch_no_dack got %0b want 0", saw_dack); else pass_cnt++;
  endtask

  task automatic test_single_store();
    // Preload d_rdata with a known load result.
    d_write = 1'b0; d_addr = 64'h80; mem_rdata = 64'h1234; d_req = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if (d_ack !== 1'b1 || d_rdata !== 64'h1234)
      $display("FAIL load_pre got ack=%0b rdata=%h want 1/1234", d_ack, d_rdata);
    else pass_cnt++;
    d_req = 1'b0;
    tick();
    d_write = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD; mem_rdata = 64'hBAD; d_req = 1'b1;
    tick();  // cycle 1
    total_cnt++;
    if (mem_en !== 1'b1 || mem_write !== 1'b0)
      $display("FAIL store_c1 got en=%0b wr=%0b want 1/0", mem_en, mem_write);
    else pass_cnt++;
    tick();  // cycle 2
    total_cnt++;
    if (mem_write !== 1'b1 || mem_addr !== 64'h100 || mem_wdata !== 64'hDEAD)
      $display("FAIL store_c2 got wr=%0b addr=%h wdata=%h want 1/100/dead", mem_write, mem_addr, mem_wdata);
    else pass_cnt++;
    tick();  // cycle 3
    total_cnt++;
    if (d_ack !== 1'b1 || mem_write !== 1'b0)
      $display("FAIL store_c3 got ack=%0b wr=%0b want 1/0", d_ack, mem_write);
    else pass_cnt++;
    total_cnt++;
    if (d_rdata !== 64'h1234) $display("FAIL store_rdata_kept got %h want 1234", d_rdata); else pass_cnt++;
    d_req = 1'b0; d_write = 1'b0;
    tick();
  endtask

  // Raise both requests in the current IDLE cycle and record ack cycles.
  task automatic run_pair(output int fa, output int da, output int nf, output int nd);
    fa = -1; da = -1; nf = 0; nd = 0;
    if_addr = 64'h500; d_addr = 64'h600; d_write = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (if_ack) begin fa = c; nf++; if_req = 1'b0; end
      if (d_ack)  begin da = c; nd++; d_req  = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_conflict();
    int fa, da, nf, nd;
    reset_dut();
    for (int p = 0; p < 2; p++) begin
      run_pair(fa, da, nf, nd);
      total_cnt++;
      if (fa !== 3) $display("FAIL pair%0d_fetch_cycle got %0d want 3", p, fa); else pass_cnt++;
      total_cnt++;
      if (da !== 7) $display("FAIL pair%0d_data_cycle got %0d want 7", p, da); else pass_cnt++;
      total_cnt++;
      if (nf !== 1 || nd !== 1)
        $display("FAIL pair%0d_ack_count got if=%0d d=%0d want 1/1", p, nf, nd);
      else pass_cnt++;
    end
  endtask

  task automatic test_input_change();
    d_write = 1'b0; d_addr = 64'h200; mem_rdata = 64'h77; d_req = 1'b1;
    tick();  // cycle 1
    total_cnt++;
    if (mem_addr !== 64'h200) $display("FAIL chg_c1_addr got %h want 200", mem_addr); else pass_cnt++;
    d_addr = 64'h300;
    d_req  = 1'b0;
    tick();  // cycle 2
    total_cnt++;
    if (mem_addr !== 64'h200 || mem_en !== 1'b1)
      $display("FAIL chg_c2 got addr=%h en=%0b want 200/1", mem_addr, mem_en);
    else pass_cnt++;
    tick();  // cycle 3
    total_cnt++;
    if (d_ack !== 1'b1 || d_rdata !== 64'h77)
      $display("FAIL chg_c3 got ack=%0b rdata=%h want 1/77", d_ack, d_rdata);
    else pass_cnt++;
    tick();  // cycle 4
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL chg_c4_busy got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    bit saw_ack = 0;
    d_write = 1'b0; d_addr = 64'h400; mem_rdata = 64'h99; d_req = 1'b1;
    tick();  // cycle 1
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy got %0b want 1", busy); else pass_cnt++;
    #2;
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL rst_mid_ctl got busy=%0b en=%0b want 0/0", busy, mem_en);
    else pass_cnt++;
    total_cnt++;
    if (d_rdata !== 64'd0) $display("FAIL rst_mid_rdata got %h want 0", d_rdata); else pass_cnt++;
    #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      saw_ack |= d_ack | if_ack;
    end
    total_cnt++;
    if (saw_ack !== 1'b0) $display("FAIL rst_mid_no_ack got %0b want 0", saw_ack); else pass_cnt++;
  endtask

  task automatic test_wait_limits();
    int f1 = -1;
    int f15 = -1;
    reset_dut();
    if_addr = 64'h8; mem_rdata = 64'h5;
    if_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (if_ack_w1 && f1 < 0) f1 = c;
      if (if_ack_w15 && f15 < 0) f15 = c;
    end
    if_req = 1'b0;
    total_cnt++;
    if (f1 !== 2) $display("FAIL wait1_latency got %0d want 2", f1); else pass_cnt++;
    total_cnt++;
    if (f15 !== 16) $display("FAIL wait15_latency got %0d want 16", f15); else pass_cnt++;
    reset_dut();
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_single_store();
    test_conflict();
    test_input_change();
    test_reset_mid_access();
    test_wait_limits();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
